// File: rtl/vga_timing_sequencer_pkg.sv
// rtl/vga_timing_sequencer_pkg.sv - mode encodings, widths and per-mode raster timing table
package vga_timing_sequencer_pkg;

  localparam int PULSE_WIDTH   = 8;
  localparam int REZ_MAX_WIDTH = 11;

  typedef enum logic [1:0] {
    MODE_640     = 2'd0,
    MODE_800     = 2'd1,
    MODE_1024    = 2'd2,
    MODE_INVALID = 2'd3
  } mode_e;

  typedef struct packed {
    logic [REZ_MAX_WIDTH-1:0] active;
    logic [PULSE_WIDTH-1:0]   fp;
    logic [PULSE_WIDTH-1:0]   sync;
    logic [PULSE_WIDTH-1:0]   bp;
  } axis_timing_t;

  // *_neg = 1 means the sync pulse is active-low (idle high).
  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
    logic         hs_neg;
    logic         vs_neg;
  } mode_timing_t;

  localparam mode_timing_t TIMING_640 = '{
    h: '{active: 11'd640, fp: 8'd16, sync: 8'd96, bp: 8'd48},
    v: '{active: 11'd480, fp: 8'd10, sync: 8'd2,  bp: 8'd33},
    hs_neg: 1'b1, vs_neg: 1'b1};

  localparam mode_timing_t TIMING_800 = '{
    h: '{active: 11'd800, fp: 8'd40, sync: 8'd128, bp: 8'd88},
    v: '{active: 11'd600, fp: 8'd1,  sync: 8'd4,   bp: 8'd23},
    hs_neg: 1'b0, vs_neg: 1'b0};

  localparam mode_timing_t TIMING_1024 = '{
    h: '{active: 11'd1024, fp: 8'd24, sync: 8'd136, bp: 8'd160},
    v: '{active: 11'd768,  fp: 8'd3,  sync: 8'd6,   bp: 8'd29},
    hs_neg: 1'b1, vs_neg: 1'b1};

  // Slot 3 is unreachable (invalid requests are rejected) and mirrors mode 0.
  localparam mode_timing_t [3:0] MODE_TABLE = {TIMING_640, TIMING_1024, TIMING_800, TIMING_640};

  function automatic logic [REZ_MAX_WIDTH-1:0] axis_total(input axis_timing_t t);
    return t.active + REZ_MAX_WIDTH'(t.fp) + REZ_MAX_WIDTH'(t.sync) + REZ_MAX_WIDTH'(t.bp);
  endfunction

endpackage

// File: rtl/vga_timing_sequencer_axis.sv
// rtl/vga_timing_sequencer_axis.sv - one raster axis counter (0..total-1) with wrap flag
module vga_axis_counter
  import vga_timing_sequencer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [REZ_MAX_WIDTH-1:0] total,
  output logic [REZ_MAX_WIDTH-1:0] count,
  output logic [REZ_MAX_WIDTH-1:0] count_next,
  output logic                     wrap
);

  logic [REZ_MAX_WIDTH-1:0] count_q, count_d;

  always_comb begin
    wrap    = enable && (count_q == total - REZ_MAX_WIDTH'(1));
    count_d = count_q;
    if (clear || wrap) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + REZ_MAX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/vga_timing_sequencer.sv
// rtl/vga_timing_sequencer.sv - VGA raster sequencer with frame-boundary mode switching
module vga_timing_sequencer
  import vga_timing_sequencer_pkg::*;
(
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Enable,
  input  logic                     Mode_req,
  input  logic [1:0]               Mode_sel,
  output logic                     Mode_busy,
  output logic                     Mode_ack,
  output logic                     Mode_err,
  output logic [1:0]               Cur_mode,
  output logic                     Hsync,
  output logic                     Vsync,
  output logic                     Video_on,
  output logic                     Frame_start,
  output logic [REZ_MAX_WIDTH-1:0] X,
  output logic [REZ_MAX_WIDTH-1:0] Y
);

  mode_e cur_mode_q, cur_mode_d, pend_mode_q, pend_mode_d;
  logic  busy_q, busy_d, ack_q, ack_d, err_q, err_d, run_q, run_d;
  logic  hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic  frame_start_q, frame_start_d;

  logic [REZ_MAX_WIDTH-1:0] h_total, v_total, x_next, y_next;
  logic [REZ_MAX_WIDTH-1:0] hs_start, hs_end, vs_start, vs_end;
  logic                     cnt_en, cnt_clr, h_wrap, v_wrap, apply;

  // run_q delays the first count so the first enabled cycle shows (0,0).
  assign cnt_en  = Enable && run_q;
  assign cnt_clr = !cnt_en;
  assign h_total = axis_total(MODE_TABLE[cur_mode_q].h);
  assign v_total = axis_total(MODE_TABLE[cur_mode_q].v);

  vga_axis_counter u_hcnt (
    .clk(Clk), .rst_n(Rst), .enable(cnt_en), .clear(cnt_clr), .total(h_total),
    .count(X), .count_next(x_next), .wrap(h_wrap)
  );

  vga_axis_counter u_vcnt (
    .clk(Clk), .rst_n(Rst), .enable(h_wrap), .clear(cnt_clr), .total(v_total),
    .count(Y), .count_next(y_next), .wrap(v_wrap)
  );

  // v_wrap is the last pixel of the frame; idle raster applies immediately.
  assign apply = busy_q && (v_wrap || !Enable);

  always_comb begin
    cur_mode_d  = cur_mode_q;
    pend_mode_d = pend_mode_q;
    busy_d      = busy_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    run_d       = Enable;
    if (apply) begin
      cur_mode_d = pend_mode_q;
      busy_d     = 1'b0;
      ack_d      = 1'b1;
    end
    if (Mode_req) begin
      if (busy_q || (Mode_sel == MODE_INVALID)) begin
        err_d = 1'b1;
      end else begin
        pend_mode_d = mode_e'(Mode_sel);
        busy_d      = 1'b1;
      end
    end
  end

  // Outputs use the mode in force next cycle so polarity flips land with Mode_ack.
  always_comb begin
    hs_start      = MODE_TABLE[cur_mode_d].h.active + REZ_MAX_WIDTH'(MODE_TABLE[cur_mode_d].h.fp);
    hs_end        = hs_start + REZ_MAX_WIDTH'(MODE_TABLE[cur_mode_d].h.sync);
    vs_start      = MODE_TABLE[cur_mode_d].v.active + REZ_MAX_WIDTH'(MODE_TABLE[cur_mode_d].v.fp);
    vs_end        = vs_start + REZ_MAX_WIDTH'(MODE_TABLE[cur_mode_d].v.sync);
    hsync_d       = MODE_TABLE[cur_mode_d].hs_neg;
    vsync_d       = MODE_TABLE[cur_mode_d].vs_neg;
    if (Enable && (x_next >= hs_start) && (x_next < hs_end)) begin
      hsync_d = !MODE_TABLE[cur_mode_d].hs_neg;
    end
    if (Enable && (y_next >= vs_start) && (y_next < vs_end)) begin
      vsync_d = !MODE_TABLE[cur_mode_d].vs_neg;
    end
    video_on_d    = Enable && (x_next < MODE_TABLE[cur_mode_d].h.active)
                           && (y_next < MODE_TABLE[cur_mode_d].v.active);
    frame_start_d = Enable && (x_next == '0) && (y_next == '0);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cur_mode_q    <= MODE_640;
      pend_mode_q   <= MODE_640;
      busy_q        <= 1'b0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      run_q         <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cur_mode_q    <= cur_mode_d;
      pend_mode_q   <= pend_mode_d;
      busy_q        <= busy_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      run_q         <= run_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign Cur_mode    = cur_mode_q;
  assign Mode_busy   = busy_q;
  assign Mode_ack    = ack_q;
  assign Mode_err    = err_q;
  assign Hsync       = hsync_q;
  assign Vsync       = vsync_q;
  assign Video_on    = video_on_q;
  assign Frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_sequencer.md
# vga_timing_sequencer

Sequences the horizontal and vertical raster counters of the VGA output path and configures them from a small table of fixed display modes. Produces aligned Hsync, Vsync, Video_on, pixel coordinates and a frame-start strobe for the pixel generator. Accepts mode-change requests over a strobe/ack handshake and applies them only at a frame boundary, so no torn frames reach the monitor.

## Interface
- PULSE_WIDTH, shared width include, width of the sync/porch timing fields; must be ≥ 8.
- REZ_MAX_WIDTH, shared width include, width of the counters and coordinates; must be ≥ 11 (max total 1344).
- Clk  in  1  pixel clock.
- Rst  in  1  reset, asynchronous, active-low.
- Enable  in  1  high: raster runs; low: raster held idle.
- Mode_req  in  1  single-cycle mode-change strobe.
- Mode_sel  in  2  requested mode, sampled with Mode_req.
- Mode_busy  out  1  a change is pending.
- Mode_ack  out  1  one-cycle pulse when the pending mode takes effect.
- Mode_err  out  1  one-cycle pulse on a rejected request.
- Cur_mode  out  2  mode currently driving the timing.
- Hsync, Vsync  out  1  sync outputs, polarity per mode.
- Video_on  out  1  high inside the active area.
- Frame_start  out  1  high for the single cycle at (X,Y)=(0,0).
- X, Y  out  REZ_MAX_WIDTH  current raster position.

## Operation
- Mode table (active/front porch/sync/back porch, sync polarity):
  - 0: 640x480, H 640/16/96/48 (total 800), V 480/10/2/33 (total 525), negative/negative.
  - 1: 800x600, H 800/40/128/88 (total 1056), V 600/1/4/23 (total 628), positive/positive.
  - 2: 1024x768, H 1024/24/136/160 (total 1344), V 768/3/6/29 (total 806), negative/negative.
  - 3: invalid.
- X counts 0..H_TOTAL-1 every cycle while Enable is high, then wraps. Y advances only when X wraps, over 0..V_TOTAL-1.
- Video_on = (X < H_ACTIVE) && (Y < V_ACTIVE).
- Hsync is asserted (active level) when H_ACTIVE+H_FP ≤ X < H_ACTIVE+H_FP+H_SYNC. Vsync uses the same rule on Y.
- All comparisons are unsigned at REZ_MAX_WIDTH.
- Handshake:
  - A Mode_req with Mode_busy=0 and Mode_sel≠3 latches a pending mode; Mode_busy rises next cycle.
  - A Mode_req with Mode_busy=1 or Mode_sel=3 is dropped; Mode_err pulses next cycle and state is unchanged.
  - Requesting the current mode is legal and is acked normally.
- Apply point: the cycle where X=H_TOTAL-1 and Y=V_TOTAL-1. On the next cycle Cur_mode takes the new value, X=Y=0 under the new timing, Mode_ack pulses and Mode_busy falls.
- A request accepted in the same cycle as an apply point waits for the following frame's apply point.
- While Enable is low:
  - X=Y=0, Video_on=0, Frame_start=0, syncs at inactive level.
  - A pending mode is applied on the next cycle, with Mode_ack.
- When Enable rises, the first running cycle shows (0,0) with Frame_start=1.

## Timing
- All outputs are registered. Hsync, Vsync, Video_on and Frame_start are computed from the next-state counts, so they align with the X/Y shown in the same cycle.
- Reset values:
  - X=0, Y=0, Cur_mode=0.
  - Hsync=1, Vsync=1 (mode 0 inactive level).
  - Video_on=0, Frame_start=0, Mode_busy=0, Mode_ack=0, Mode_err=0.
- Reset asserted mid-frame or mid-request clears the pending mode and returns to mode 0 immediately.
- Handshake latency: request → Mode_busy is 1 cycle; apply point → Mode_ack is 1 cycle; invalid request → Mode_err is 1 cycle.
- A sync level change caused by a polarity change between modes occurs in the same cycle as Mode_ack.

## Structure
- Shared package/include holds:
  - the mode encoding constants (MODE_640, MODE_800, MODE_1024),
  - the per-mode timing constants,
  - the width parameters.
- Natural sub-module: vga_axis_counter.
  - Inputs: enable, clear, total.
  - Outputs: count, wrap flag.
  - Instantiated twice; the horizontal wrap flag drives the vertical enable.
- The mode register, pending register and handshake logic live in the top module.

## Test plan
- Reset, Enable=1, mode 0 → Hsync low for X 656..751, Vsync low for Y 490..491, Video_on for X<640 and Y<480, Frame_start every 420000 cycles.
- Mode_req with Mode_sel=1 at Y=100 → Mode_busy=1 next cycle. After (799,524): Mode_ack pulse, Cur_mode=1, X=Y=0, Hsync high for X 840..967, frame period 663168.
- Mode_req with Mode_sel=3, and a second Mode_req while Mode_busy=1 → Mode_err pulses, Cur_mode and pending mode unchanged.
- Mode_req at exactly (799,524) → not applied at that boundary; applied one full frame later.
- Enable low with a pending mode 2 → ack next cycle, outputs idle. Enable high → (0,0) with Frame_start=1, H_TOTAL=1344.
- Rst asserted mid-frame with mode 1 pending → all outputs return to reset values immediately, Cur_mode=0, no Mode_ack.
